// File: rtl/ddram_bram_responder.sv
// DDRAM responder backed by block RAM: single/burst reads and byte-masked writes, 64-bit words.
// Read latency RD_LATENCY cycles from acceptance to the first beat, then one beat per cycle.
// Backpressure: busy held through a read burst; optional LFSR stall injection (DDRAM_STALL_INJECT_EN).
module ddram_bram_responder #(
  parameter int ADDR_W     = 12,
  parameter int RD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        ddram_busy,
  input  logic [7:0]  ddram_burstcnt,
  input  logic [28:0] ddram_addr,
  input  logic        ddram_rd,
  input  logic [63:0] ddram_din,
  input  logic [7:0]  ddram_be,
  input  logic        ddram_we,
  output logic [63:0] ddram_dout,
  output logic        ddram_dout_ready,
  output logic        proto_err
);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;

  localparam int         DEPTH = 1 << ADDR_W;
  localparam logic [9:0] LAT   = 10'(RD_LATENCY);

  state_t            state;
  logic [ADDR_W-1:0] base;   // first-beat address of the current burst
  logic [8:0]        beats;  // burst length, 1..255
  logic [9:0]        cnt;    // read: cycles since acceptance minus one; write: next beat index
  logic [63:0]       mem [DEPTH];

  logic [8:0]        req_n;
  logic [9:0]        rd_pos;
  logic [9:0]        rd_k;
  logic              accept_rd;
  logic              rd_issue;
  logic              rd_done;
  logic              wr_vld;
  logic              stall_nxt;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic              unused_addr;

  assign unused_addr = ^ddram_addr[28:ADDR_W];

  assign req_n     = (ddram_burstcnt == 8'd0) ? 9'd1 : {1'b0, ddram_burstcnt};
  assign accept_rd = (state == IDLE) && !ddram_busy && ddram_rd && !ddram_we;
  assign rd_pos    = cnt + 10'd2;
  assign rd_k      = rd_pos - LAT;
  // Last beat is on the outputs in this cycle; busy drops in the next one.
  assign rd_done   = (state == RD_BURST) && (cnt == LAT + {1'b0, beats} - 10'd2);

  assign wr_vld  = reset_n && !ddram_busy && ddram_we && (state == IDLE || state == WR_BURST);
  assign wr_addr = (state == WR_BURST) ? base + ADDR_W'(cnt) : ddram_addr[ADDR_W-1:0];

  // Select which beat (if any) is fetched into the output register this cycle.
  always_comb begin
    rd_issue = 1'b0;
    rd_addr  = ddram_addr[ADDR_W-1:0];
    if (state == RD_BURST) begin
      rd_issue = (rd_pos >= LAT) && (rd_k < {1'b0, beats});
      rd_addr  = base + ADDR_W'(rd_k);
    end else if (accept_rd && (RD_LATENCY == 1)) begin
      rd_issue = 1'b1;
    end
  end

`ifdef DDRAM_STALL_INJECT_EN
  logic [15:0] lfsr;
  logic [15:0] lfsr_nxt;

  assign lfsr_nxt  = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign stall_nxt = (lfsr_nxt[1:0] == 2'b00);

  // Free-running stall pattern generator.
  always_ff @(posedge clk) begin
    if (!reset_n) lfsr <= 16'hACE1;
    else          lfsr <= lfsr_nxt;
  end
`else
  assign stall_nxt = 1'b0;
`endif

  // Memory write port; contents survive reset so aborted bursts keep their written beats.
  always_ff @(posedge clk) begin
    if (wr_vld) begin
      for (int b = 0; b < 8; b++) begin
        if (ddram_be[b]) mem[wr_addr][8*b +: 8] <= ddram_din[8*b +: 8];
      end
    end
  end

  // Command FSM with registered busy, read-data and error outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= IDLE;
      base             <= '0;
      beats            <= 9'd1;
      cnt              <= '0;
      ddram_busy       <= 1'b1;
      ddram_dout_ready <= 1'b0;
      ddram_dout       <= '0;
      proto_err        <= 1'b0;
    end else begin
      ddram_dout_ready <= rd_issue;
      if (rd_issue) ddram_dout <= mem[rd_addr];
      ddram_busy <= accept_rd || ((state == RD_BURST) && !rd_done) || stall_nxt;
      case (state)
        IDLE: begin
          if (!ddram_busy && ddram_we) begin
            base  <= ddram_addr[ADDR_W-1:0];
            beats <= req_n;
            cnt   <= 10'd1;
            if (ddram_rd) proto_err <= 1'b1;
            if (req_n > 9'd1) state <= WR_BURST;
          end else if (accept_rd) begin
            base  <= ddram_addr[ADDR_W-1:0];
            beats <= req_n;
            cnt   <= '0;
            state <= RD_BURST;
          end
        end
        RD_BURST: begin
          cnt <= cnt + 10'd1;
          if (rd_done) state <= IDLE;
        end
        WR_BURST: begin
          if (ddram_rd) proto_err <= 1'b1;
          if (wr_vld) begin
            cnt <= cnt + 10'd1;
            if (cnt == {1'b0, beats} - 10'd1) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddram_bram_responder.sv
// Bench for ddram_bram_responder: directed cases plus randomized traffic against an array model.
// Reads are checked beat by beat for timing and data; busy is checked through each read burst.
// Inputs driven and outputs sampled on the falling edge.
`timescale 1ns/1ps
module tb_ddram_bram_responder;

  localparam int AW    = 12;
  localparam int LAT   = 2;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ddram_busy;
  logic [7:0]  ddram_burstcnt = '0;
  logic [28:0] ddram_addr = '0;
  logic        ddram_rd = 1'b0;
  logic [63:0] ddram_din = '0;
  logic [7:0]  ddram_be = '0;
  logic        ddram_we = 1'b0;
  logic [63:0] ddram_dout;
  logic        ddram_dout_ready;
  logic        proto_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] model [DEPTH];
  logic [63:0] wdat  [256];
  logic [7:0]  wbe   [256];

  ddram_bram_responder #(.ADDR_W(AW), .RD_LATENCY(LAT)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .ddram_busy       (ddram_busy),
    .ddram_burstcnt   (ddram_burstcnt),
    .ddram_addr       (ddram_addr),
    .ddram_rd         (ddram_rd),
    .ddram_din        (ddram_din),
    .ddram_be         (ddram_be),
    .ddram_we         (ddram_we),
    .ddram_dout       (ddram_dout),
    .ddram_dout_ready (ddram_dout_ready),
    .proto_err        (proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Called on a falling edge; returns on a falling edge where busy is low.
  task automatic wait_not_busy();
    int t;
    t = 0;
    while (ddram_busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t == 200) chk("busy_timeout", 64'(ddram_busy), 64'd0);
  endtask

  // wait_mode: 0 none, 1 random wait states, 2 one wait before the third beat.
  task automatic do_write(input logic [28:0] addr, input logic [7:0] bc, input int wait_mode);
    int n;
    logic [AW-1:0] a;
    logic [AW-1:0] ak;
    n = (bc == 8'd0) ? 1 : int'(bc);
    a = addr[AW-1:0];
    wait_not_busy();
    ddram_addr = addr; ddram_burstcnt = bc; ddram_rd = 1'b0;
    ddram_we = 1'b1; ddram_din = wdat[0]; ddram_be = wbe[0];
    @(posedge clk);
    model[a] = merge(model[a], wdat[0], wbe[0]);
    for (int k = 1; k < n; k++) begin
      @(negedge clk);
      ddram_we = 1'b0;
      ddram_addr = 29'($urandom);
      if ((wait_mode == 1 && $urandom_range(0, 3) == 0) || (wait_mode == 2 && k == 2))
        @(negedge clk);
      wait_not_busy();
      ddram_we = 1'b1; ddram_din = wdat[k]; ddram_be = wbe[k];
      @(posedge clk);
      ak = a + AW'(k);
      model[ak] = merge(model[ak], wdat[k], wbe[k]);
    end
    @(negedge clk);
    ddram_we = 1'b0;
  endtask

  task automatic do_read(input logic [28:0] addr, input logic [7:0] bc);
    int n;
    logic [AW-1:0] a;
    logic [AW-1:0] ak;
    n = (bc == 8'd0) ? 1 : int'(bc);
    a = addr[AW-1:0];
    wait_not_busy();
    ddram_addr = addr; ddram_burstcnt = bc; ddram_rd = 1'b1; ddram_we = 1'b0;
    ddram_be = 8'($urandom);
    @(posedge clk);
    for (int j = 1; j <= LAT + n; j++) begin
      @(negedge clk);
      chk("rd_ready", 64'(ddram_dout_ready), 64'(j >= LAT && j < LAT + n));
      if (j >= LAT && j < LAT + n) begin
        ak = a + AW'(j - LAT);
        chk("rd_data", ddram_dout, model[ak]);
      end else if (j == LAT + n) begin
        ak = a + AW'(n - 1);
        chk("rd_hold", ddram_dout, model[ak]);
      end
`ifndef DDRAM_STALL_INJECT_EN
      chk("rd_busy", 64'(ddram_busy), 64'(j < LAT + n));
`else
      if (j < LAT + n) chk("rd_busy", 64'(ddram_busy), 64'd1);
`endif
      // Requests raised while busy must be ignored.
      if (j < LAT + n) begin
        ddram_rd = 1'($urandom_range(0, 1));
        ddram_we = 1'($urandom_range(0, 1));
        ddram_din = {$urandom, $urandom};
      end else begin
        ddram_rd = 1'b0;
        ddram_we = 1'b0;
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [28:0] ra;
    logic [7:0]  rb;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(ddram_busy), 64'd1);
    chk("rst_ready", 64'(ddram_dout_ready), 64'd0);
    chk("rst_perr", 64'(proto_err), 64'd0);
    chk("rst_dout", ddram_dout, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
`ifndef DDRAM_STALL_INJECT_EN
    chk("rst_release_busy", 64'(ddram_busy), 64'd0);
`endif

    // Fill memory with known random content using long bursts (wrap included).
    for (int blk = 0; blk < 17; blk++) begin
      for (int k = 0; k < 255; k++) begin wdat[k] = {$urandom, $urandom}; wbe[k] = 8'hFF; end
      do_write(29'(blk * 255), 8'd255, 0);
    end

    // Single write then read-after-write.
    wdat[0] = 64'h0123_4567_89AB_CDEF; wbe[0] = 8'hFF;
    do_write(29'h10, 8'd1, 0);
    do_read(29'h10, 8'd1);

    // Partial byte-enable write.
    wdat[0] = 64'd0; wbe[0] = 8'hFF;
    do_write(29'h20, 8'd1, 0);
    wdat[0] = 64'hFFFF_FFFF_FFFF_FFFF; wbe[0] = 8'h0F;
    do_write(29'h20, 8'd1, 0);
    do_read(29'h20, 8'd1);
    chk("be_model", model[12'h020], merge(64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F));

    // Burst with address wrap and a wait state; be=0 beat counts but changes nothing.
    for (int k = 0; k < 4; k++) begin wdat[k] = 64'(k + 1); wbe[k] = 8'hFF; end
    do_write(29'h0FFE, 8'd4, 2);
    do_read(29'h0FFE, 8'd4);
    do_read(29'h0000, 8'd1);
    do_read(29'h1001, 8'd0);
    wdat[0] = 64'hDEAD; wbe[0] = 8'h00;
    wdat[1] = 64'hBEEF; wbe[1] = 8'h03;
    do_write(29'h0FFF, 8'd2, 0);
    do_read(29'h0FFF, 8'd2);

    // Reset in the middle of a read burst discards remaining beats.
    wait_not_busy();
    ddram_addr = 29'h40; ddram_burstcnt = 8'd8; ddram_rd = 1'b1;
    @(posedge clk);
    @(negedge clk); ddram_rd = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_ready", 64'(ddram_dout_ready), 64'd0);
    chk("abort_dout", ddram_dout, 64'd0);
    chk("abort_busy", 64'(ddram_busy), 64'd1);
    reset_n = 1'b1;
    @(negedge clk);
    chk("abort_ready2", 64'(ddram_dout_ready), 64'd0);

    // Reset in the middle of a write burst keeps the beats already written.
    wait_not_busy();
    ddram_addr = 29'h80; ddram_burstcnt = 8'd4; ddram_we = 1'b1;
    ddram_din = 64'hAAAA_0000; ddram_be = 8'hFF;
    @(posedge clk);
    model[12'h080] = 64'hAAAA_0000;
    @(negedge clk); ddram_din = 64'hAAAA_0001;
    @(posedge clk);
    model[12'h081] = 64'hAAAA_0001;
    @(negedge clk); ddram_we = 1'b0; reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    do_read(29'h80, 8'd4);
    chk("perr_clean", 64'(proto_err), 64'd0);

    // Simultaneous read and write in idle: write wins, no read beats, sticky error.
    wait_not_busy();
    ddram_addr = 29'h300; ddram_burstcnt = 8'd1; ddram_rd = 1'b1; ddram_we = 1'b1;
    ddram_din = 64'h5555_6666_7777_8888; ddram_be = 8'hFF;
    @(posedge clk);
    model[12'h300] = 64'h5555_6666_7777_8888;
    @(negedge clk); ddram_rd = 1'b0; ddram_we = 1'b0;
    for (int j = 0; j < LAT + 3; j++) begin
      chk("perr_noread", 64'(ddram_dout_ready), 64'd0);
      @(negedge clk);
    end
    chk("perr_set", 64'(proto_err), 64'd1);
    do_read(29'h300, 8'd1);

    // Randomized traffic.
    for (int t = 0; t < 400; t++) begin
      ra = 29'($urandom);
      rb = 8'($urandom_range(0, 9));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 10; k++) begin
          wdat[k] = {$urandom, $urandom};
          wbe[k]  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        end
        do_write(ra, rb, 1);
      end else begin
        do_read(ra, rb);
      end
    end
    chk("perr_sticky", 64'(proto_err), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
